// File: rtl/boot_stream_loader_if.sv
// Word-stream handshake plus instruction-memory boot port of the boot loader.
// The loader is the slave of the stream and drives the boot port.
interface boot_stream_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              boot_up;
    logic              boot_web;
    logic [ADDR_W-1:0] boot_addr;
    logic [DATA_W-1:0] boot_datai;

    modport master (
        output in_valid, in_data,
        input  in_ready, boot_up, boot_web, boot_addr, boot_datai
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, boot_up, boot_web, boot_addr, boot_datai
    );
endinterface

// File: rtl/boot_stream_loader.sv
// Streams a programmed number of words into instruction memory, keeps a checksum,
// and holds the CPU in reset until the image has drained and optionally verified.
module boot_stream_loader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int HOLD_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic                chk_en,
    input  logic [DATA_W-1:0]   exp_sum,
    boot_stream_loader_if.slave bus,
    output logic                cpu_rst_n,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   sum_out
);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CHECK, RUN, ERROR} state_t;

    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      HOLD_LAST = 4'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [3:0]        hold_q, hold_d;
    logic              chk_en_q, chk_en_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              boot_up_q, boot_up_d;
    logic              boot_web_q, boot_web_d;
    logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
    logic [DATA_W-1:0] boot_datai_q, boot_datai_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer;
    logic              launch;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        count_d      = count_q;
        hold_d       = hold_q;
        chk_en_d     = chk_en_q;
        sum_d        = sum_q;
        boot_web_d   = 1'b1;
        boot_addr_d  = boot_addr_q;
        boot_datai_d = boot_datai_q;

        xfer   = bus.in_valid && (state_q == LOAD);
        launch = start && (state_q inside {IDLE, RUN, ERROR});

        // start only takes effect where abort has no meaning, so it wins there
        if (launch) begin
            base_d   = base_addr;
            len_d    = length;
            chk_en_d = chk_en;
            sum_d    = '0;
            count_d  = '0;
            hold_d   = '0;
            if (length > DEPTH_L)
                state_d = ERROR;
            else if (length == '0)
                state_d = DRAIN;
            else
                state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (xfer) begin
                        boot_web_d   = 1'b0;
                        boot_addr_d  = base_q + count_q[ADDR_W-1:0];
                        boot_datai_d = bus.in_data;
                        sum_d        = sum_q + bus.in_data;
                        count_d      = count_q + 1'b1;
                        if (count_q == len_q - 1'b1) begin
                            state_d = DRAIN;
                            hold_d  = '0;
                        end
                    end
                end
                DRAIN: begin
                    if (abort)
                        state_d = IDLE;
                    else if (hold_q == HOLD_LAST)
                        state_d = CHECK;
                    else
                        hold_d = hold_q + 1'b1;
                end
                CHECK: begin
                    if (chk_en_q && (sum_q != exp_sum))
                        state_d = ERROR;
                    else
                        state_d = RUN;
                end
                default: ;
            endcase
        end

        // status outputs are registered copies of the state being entered
        busy_d      = state_d inside {LOAD, DRAIN, CHECK};
        boot_up_d   = state_d inside {LOAD, DRAIN, CHECK};
        done_d      = (state_d == RUN);
        err_d       = (state_d == ERROR);
        cpu_rst_n_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            chk_en_q     <= 1'b0;
            sum_q        <= '0;
            boot_up_q    <= 1'b0;
            boot_web_q   <= 1'b1;
            boot_addr_q  <= '0;
            boot_datai_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            chk_en_q     <= chk_en_d;
            sum_q        <= sum_d;
            boot_up_q    <= boot_up_d;
            boot_web_q   <= boot_web_d;
            boot_addr_q  <= boot_addr_d;
            boot_datai_q <= boot_datai_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = (state_q == LOAD);
    assign bus.boot_up    = boot_up_q;
    assign bus.boot_web   = boot_web_q;
    assign bus.boot_addr  = boot_addr_q;
    assign bus.boot_datai = boot_datai_q;
    assign cpu_rst_n      = cpu_rst_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign sum_out        = sum_q;

endmodule

// File: tb/tb_boot_stream_loader.sv
// Directed bench for boot_stream_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every write the loader issues.
module tb_boot_stream_loader;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int DEPTH    = 256;
    localparam int HOLD_CYC = 2;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              start     = 1'b0;
    logic              abort     = 1'b0;
    logic              chk_en    = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length    = '0;
    logic [DATA_W-1:0] exp_sum   = '0;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] sum_out;

    boot_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

    boot_stream_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .chk_en(chk_en), .exp_sum(exp_sum),
        .bus(bif), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err),
        .sum_out(sum_out)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               expQ[$];
    logic [DATA_W-1:0] words[$];
    logic [ADDR_W-1:0] addrs[$];
    bit                vpat[$];
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic doStart(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                           input logic c, input logic [DATA_W-1:0] e);
        base_addr = b;
        length    = l;
        chk_en    = c;
        exp_sum   = e;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Drives words[0..n-1] honouring the in_valid pattern; each accepted word
    // becomes one expected write at its hand-listed address.
    task automatic applyStimulus(input int n);
        int  idx   = 0;
        int  p     = 0;
        int  guard = 0;
        bit  v;
        while (idx < n && guard < 500) begin
            v = (vpat.size() == 0) ? 1'b1 : vpat[p % vpat.size()];
            bif.in_valid = v;
            bif.in_data  = words[idx];
            if (v && bif.in_ready) begin
                expQ.push_back('{addr: addrs[idx], data: words[idx]});
                idx++;
            end
            p++;
            guard++;
            tick();
        end
        bif.in_valid = 1'b0;
        if (guard >= 500)
            checkOutput("stream_timeout", idx, n);
    endtask

    task automatic waitRun(input int maxCyc);
        for (int i = 0; i < maxCyc; i++) begin
            if (done || err) break;
            tick();
        end
        checkOutput("wait_timeout", done || err, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bif.boot_web === 1'b0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0h, required no write",
                         bif.boot_addr, bif.boot_datai);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("write_addr", DATA_W'(bif.boot_addr), DATA_W'(e.addr));
                checkOutput("write_data", bif.boot_datai, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_boot_up", bif.boot_up, 0);
        checkOutput("rst_boot_web", bif.boot_web, 1);
        checkOutput("rst_boot_addr", DATA_W'(bif.boot_addr), 0);
        checkOutput("rst_boot_datai", bif.boot_datai, 0);
        checkOutput("rst_in_ready", bif.in_ready, 0);
        checkOutput("rst_cpu_rst_n", cpu_rst_n, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_sum", sum_out, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic load of 45 words");
        words.delete(); addrs.delete(); vpat.delete();
        for (int i = 0; i < 45; i++) begin
            words.push_back(DATA_W'(i * 3));
            addrs.push_back(ADDR_W'(i));
        end
        doStart(8'd0, 9'd45, 1'b1, 32'd2970);
        checkOutput("load_busy", busy, 1);
        checkOutput("load_in_ready", bif.in_ready, 1);
        checkOutput("load_boot_up", bif.boot_up, 1);
        applyStimulus(45);
        tick();
        tick();
        checkOutput("drain_boot_up", bif.boot_up, 1);
        checkOutput("drain_cpu_rst_n", cpu_rst_n, 0);
        tick();
        checkOutput("run_boot_up", bif.boot_up, 0);
        checkOutput("run_cpu_rst_n", cpu_rst_n, 1);
        checkOutput("run_done", done, 1);
        checkOutput("basic_sum", sum_out, 32'd2970);
        checkOutput("basic_pending", expQ.size(), 0);

        $display("[TB] backpressure");
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        addrs = '{8'd0, 8'd1, 8'd2, 8'd3};
        vpat  = '{1, 0, 0, 1, 1, 0, 1};
        doStart(8'd0, 9'd4, 1'b0, 32'd0);
        checkOutput("reload_done", done, 0);
        checkOutput("reload_cpu_rst_n", cpu_rst_n, 0);
        applyStimulus(4);
        vpat.delete();
        waitRun(10);
        checkOutput("bp_done", done, 1);
        checkOutput("bp_sum", sum_out, 32'hAA);
        checkOutput("bp_pending", expQ.size(), 0);

        $display("[TB] address wrap-around");
        words.delete();
        for (int i = 0; i < 10; i++) words.push_back(DATA_W'(32'h100 + i));
        addrs = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2, 8'd3};
        doStart(8'd250, 9'd10, 1'b1, 32'd2605);
        applyStimulus(10);
        waitRun(10);
        checkOutput("wrap_done", done, 1);
        checkOutput("wrap_err", err, 0);
        checkOutput("wrap_sum", sum_out, 32'd2605);
        checkOutput("wrap_pending", expQ.size(), 0);

        $display("[TB] bad checksum then empty load");
        words = '{32'd5, 32'd7};
        addrs = '{8'd0, 8'd1};
        doStart(8'd0, 9'd2, 1'b1, 32'd13);
        applyStimulus(2);
        waitRun(10);
        checkOutput("bad_err", err, 1);
        checkOutput("bad_done", done, 0);
        checkOutput("bad_cpu_rst_n", cpu_rst_n, 0);
        checkOutput("bad_sum", sum_out, 32'd12);
        doStart(8'd0, 9'd0, 1'b0, 32'd0);
        checkOutput("empty_err", err, 0);
        checkOutput("empty_busy", busy, 1);
        checkOutput("empty_boot_up", bif.boot_up, 1);
        repeat (HOLD_CYC) tick();
        checkOutput("empty_done_early", done, 0);
        tick();
        checkOutput("empty_done", done, 1);
        checkOutput("empty_cpu_rst_n", cpu_rst_n, 1);
        checkOutput("empty_pending", expQ.size(), 0);

        $display("[TB] illegal length");
        doStart(8'd0, 9'd257, 1'b0, 32'd0);
        checkOutput("illegal_err", err, 1);
        checkOutput("illegal_busy", busy, 0);
        checkOutput("illegal_done", done, 0);
        checkOutput("illegal_boot_up", bif.boot_up, 0);
        repeat (3) tick();
        checkOutput("illegal_err_hold", err, 1);
        checkOutput("illegal_pending", expQ.size(), 0);

        $display("[TB] abort after 3 of 8 words");
        words.delete(); addrs.delete();
        for (int i = 0; i < 8; i++) begin
            words.push_back(DATA_W'(32'hA0 + i));
            addrs.push_back(ADDR_W'(16 + i));
        end
        doStart(8'd16, 9'd8, 1'b0, 32'd0);
        checkOutput("abort_err_cleared", err, 0);
        applyStimulus(3);
        bif.in_valid = 1'b1;
        bif.in_data  = words[3];
        abort        = 1'b1;
        tick();
        abort        = 1'b0;
        bif.in_valid = 1'b0;
        checkOutput("abort_boot_up", bif.boot_up, 0);
        checkOutput("abort_boot_web", bif.boot_web, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_in_ready", bif.in_ready, 0);
        checkOutput("abort_cpu_rst_n", cpu_rst_n, 0);
        checkOutput("abort_sum", sum_out, 32'h1E3);
        repeat (3) tick();
        checkOutput("abort_pending", expQ.size(), 0);

        $display("[TB] reset mid-load");
        words = '{32'h55, 32'h66, 32'h77, 32'h88, 32'h99, 32'hAA, 32'hBB, 32'hCC};
        addrs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        doStart(8'd0, 9'd8, 1'b0, 32'd0);
        applyStimulus(2);
        tick();
        bif.in_valid = 1'b1;
        bif.in_data  = words[2];
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_boot_up", bif.boot_up, 0);
        checkOutput("mid_rst_boot_web", bif.boot_web, 1);
        checkOutput("mid_rst_boot_addr", DATA_W'(bif.boot_addr), 0);
        checkOutput("mid_rst_boot_datai", bif.boot_datai, 0);
        checkOutput("mid_rst_in_ready", bif.in_ready, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_sum", sum_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        bif.in_valid = 1'b0;
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_in_ready", bif.in_ready, 0);
        checkOutput("post_rst_pending", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
